// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: load/store op encoding, LSU states and
// lane/alignment helpers used by the load/store unit.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ERR  = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Low address bits that must be zero for each access size.
  localparam logic [1:0] LSU_BYTE_MASK = 2'b00;
  localparam logic [1:0] LSU_HALF_MASK = 2'b01;
  localparam logic [1:0] LSU_WORD_MASK = 2'b11;

  function automatic logic lsu_is_store(input logic [2:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Any encoding that is not a byte or halfword access behaves as a word.
  function automatic logic [1:0] lsu_align_mask(input logic [2:0] op);
    case (op)
      LB, LBU, SB: return LSU_BYTE_MASK;
      LH, LHU, SH: return LSU_HALF_MASK;
      default:     return LSU_WORD_MASK;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] lo);
    return |(lo & lsu_align_mask(op));
  endfunction

  function automatic logic [3:0] lsu_byteenable(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      LB, LBU, SB: return 4'b0001 << lo;
      LH, LHU, SH: return lo[1] ? 4'b1100 : 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across all lanes; byteenable picks the lane.
  function automatic logic [31:0] lsu_steer(input logic [2:0] op, input logic [31:0] wdata);
    case (op)
      SB:      return {4{wdata[7:0]}};
      SH:      return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_extract.sv
// Load data extraction: shifts the addressed lane(s) down to bit 0 and
// sign- or zero-extends. Stores produce zero.
module mips_cpu_lsu_extract
  import mips_cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] readdata,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Lane select then extension by op.
  always_comb begin
    shifted = readdata >> {addr_lo, 3'b000};
    data    = '0;
    case (op)
      LB:         data = {{24{shifted[7]}}, shifted[7:0]};
      LBU:        data = {24'h000000, shifted[7:0]};
      LH:         data = {{16{shifted[15]}}, shifted[15:0]};
      LHU:        data = {16'h0000, shifted[15:0]};
      SB, SH, SW: data = '0;
      default:    data = readdata;
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Memory-stage load/store unit. Runs one Avalon-MM read or write per
// accepted request and returns the extended load result with a one-cycle
// rsp_valid pulse. Misaligned requests skip the bus and report an error.
//
//   state | meaning
//   IDLE  | ready for a request (req_ready=1)
//   BUS   | strobe asserted, waiting for waitrequest low
//   ERR   | misaligned request, no bus access
//   RESP  | rsp_valid pulse, result registers valid
module mips_cpu_lsu
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_addr_err
);

  lsu_state_t        state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] ext_data;
  logic              in_bus;
  logic              is_store;

  mips_cpu_lsu_extract u_extract (
    .op       (op_q),
    .addr_lo  (addr_q[1:0]),
    .readdata (avm_readdata),
    .data     (ext_data)
  );

  assign in_bus   = (state == BUS);
  assign is_store = lsu_is_store(op_q);

  // Bus outputs come straight from the registered request so they stay
  // stable for as long as the slave stalls.
  assign avm_read       = in_bus & ~is_store;
  assign avm_write      = in_bus & is_store;
  assign avm_address    = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign avm_byteenable = in_bus ? lsu_byteenable(op_q, addr_q[1:0]) : 4'b0000;
  assign avm_writedata  = avm_write ? lsu_steer(op_q, wdata_q) : '0;

  assign req_ready    = (state == IDLE);
  assign rsp_valid    = (state == RESP);
  assign rsp_data     = rsp_data_q;
  assign rsp_addr_err = rsp_err_q;

  // Request capture, state sequencing and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            state      <= lsu_misaligned(req_op, req_addr[1:0]) ? ERR : BUS;
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            rsp_data_q <= ext_data;
            state      <= RESP;
          end
        end
        ERR: begin
          rsp_err_q <= 1'b1;
          state     <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_cpu_lsu.md
Name: mips_cpu_lsu

Overview:
- Load/store unit in the memory stage, directly downstream of the ALU.
- Takes the ALU result as effective address plus rt store data, and runs one Avalon-MM style bus transaction per request.
- Performs byte-lane steering, byte-enable generation and sign/zero extension of load data.
- Multi-cycle: the CPU stalls on req_ready low and takes the result on rsp_valid.

Parameters:
ADDR_W, 32, bus/effective address width
DATA_W, 32, bus data width (fixed at 32; any other value is unsupported)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present this cycle
req_ready  out  1  unit can accept a request (high only in IDLE)
req_op  in  3  lsu_op_t: LB, LBU, LH, LHU, LW, SB, SH, SW
req_addr  in  32  effective address (ALU alu_out)
req_wdata  in  32  store data (rt)
avm_address  out  32  word-aligned bus address, {req_addr[31:2],2'b00}
avm_read  out  1  bus read strobe
avm_write  out  1  bus write strobe
avm_byteenable  out  4  active byte lanes
avm_writedata  out  32  lane-steered store data
avm_readdata  in  32  bus read data
avm_waitrequest  in  1  slave stall
rsp_valid  out  1  one-cycle pulse: operation complete
rsp_data  out  32  extended load result (0 for stores)
rsp_addr_err  out  1  misaligned address, valid with rsp_valid

Behaviour:
- Reset (async, rst_n low): state=IDLE. All outputs 0 except req_ready=1. Applies mid-transaction: the bus strobe drops immediately and the pending op is discarded.
- Handshake: a request is accepted on a rising edge with req_valid & req_ready. Op, address and wdata are registered; inputs are ignored afterwards.
- States: IDLE -> BUS (aligned) or ERR (misaligned); BUS -> RESP once avm_waitrequest is low on an edge; ERR -> RESP; RESP -> IDLE.
- BUS: avm_read or avm_write (exactly one) held high together with address, byteenable and writedata. All are stable while avm_waitrequest=1.
- Read data is captured on the edge where BUS sees waitrequest=0.
- RESP: rsp_valid=1 for exactly one cycle. rsp_data and rsp_addr_err are valid in that cycle and held until the next accept.
- Latency: accept edge +1 strobe, +N wait cycles, +1 RESP. Minimum 3 cycles from accept to rsp_valid.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
  - Misaligned: no bus strobe, rsp_addr_err=1, rsp_data=0, ERR -> RESP, same minimum latency.
- Byte lanes (little-endian lanes), lane k = bits [8k+7:8k], k=addr[1:0]:
  - SB: byteenable = 1<<k, writedata = {4{wdata[7:0]}}.
  - SH: byteenable = 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1), writedata = {2{wdata[15:0]}}.
  - SW: byteenable = 4'b1111, writedata = wdata.
  - Loads: byteenable is the same pattern as the matching store.
- Load extension: the selected lane(s) are shifted to bits [7:0] or [15:0].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW is unmodified.
- req_valid in a non-IDLE state is not accepted; the upstream holds the request.
- req_op outside the enum is treated as LW.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - lsu_op_t enum (LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7);
  - lsu_state_t (IDLE, BUS, ERR, RESP);
  - alignment helper constants.
- One natural sub-module: mips_cpu_lsu_extract, combinational. Maps (op, addr[1:0], readdata) to the extended rsp_data. It is reused by the bench as its reference model.

Test Plan:
- LW at addr 0x1000, readdata 0xDEADBEEF, waitrequest 0 -> avm_read for 1 cycle, byteenable 4'hF, rsp_data 0xDEADBEEF, rsp_valid at accept+3.
- LB at addr 0x2003, readdata 0x80FF1234 -> byteenable 4'b1000, rsp_data 0xFFFFFF80.
- LBU at 0x2003, same readdata -> rsp_data 0x00000080.
- LHU at 0x2002 with readdata 0x80FF1234 -> rsp_data 0x000080FF.
- SH at 0x3002, wdata 0x0000ABCD, waitrequest high 4 cycles -> avm_write held 5 cycles, writedata 0xABCDABCD, byteenable 4'b1100, stable throughout, rsp_valid once.
- LW at 0x1001 -> no avm_read/avm_write, rsp_addr_err=1, rsp_data 0 at accept+3.
- Back-to-back: req_valid held high across SW then LW -> req_ready low during BUS/RESP, second accept the cycle after RESP.
- Reset mid-read: rst_n low for 1 cycle while waitrequest=1 -> avm_read=0 immediately, req_ready=1, no rsp_valid.
